// File: rtl/onehot_decode8.sv
// Buffered 3-to-8 one-hot decoder: a small FIFO of code/z pairs with a decoded head entry.
// Optional sticky consistency check (err port) enabled by defining ONEHOT_DECODE8_ERRCHK_EN.
module onehot_decode8 #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               code,
    input  logic                     z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   level
`ifdef ONEHOT_DECODE8_ERRCHK_EN
    ,
    output logic                     err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    head;
    logic          push;
    logic          pop;

    assign in_ready  = (level != FULL);
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // storage needs no reset: the head is only visible while level is nonzero
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {z, code};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head     = mem[rd_ptr];
    assign out      = (out_valid && !head[3]) ? (8'b1 << head[2:0]) : 8'b0;
    assign out_zero = out_valid && head[3];

`ifdef ONEHOT_DECODE8_ERRCHK_EN
    // z=1 alongside a nonzero code means the encoder side disagrees with itself
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (push && z && (code != 3'b000)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_decode8.sv
// Self-checking bench for onehot_decode8: queue-based reference model with randomized stalls.
module tb_onehot_decode8;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    code;
    logic          z;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out;
    logic          out_zero;
    logic [LW-1:0] level;
`ifdef ONEHOT_DECODE8_ERRCHK_EN
    logic          err;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] q[$];

    onehot_decode8 #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_zero  (out_zero),
        .level     (level)
`ifdef ONEHOT_DECODE8_ERRCHK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_out();
        logic [7:0] w;
        if (q.size() == 0) return 8'h00;
        if (q[0][3]) return 8'h00;
        w = 8'h01;
        return w << q[0][2:0];
    endfunction

    function automatic logic exp_zero();
        if (q.size() == 0) return 1'b0;
        return q[0][3];
    endfunction

    // drive one cycle and advance the model by the buffer's accept/pop rules
    task automatic step(input logic v, input logic [2:0] c, input logic zz, input logic r);
        bit push_ok;
        bit pop_ok;
        logic [3:0] tmp;
        in_valid  = v;
        code      = c;
        z         = zz;
        out_ready = r;
        push_ok = v && (q.size() < DEPTH);
        pop_ok  = r && (q.size() > 0);
        @(posedge clk);
        if (pop_ok) tmp = q.pop_front();
        if (push_ok) q.push_back({zz, c});
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        in_valid = 0; code = 0; z = 0; out_ready = 0;
        rst_n = 0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== '0 || out !== 8'h00 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: out_valid=%b in_ready=%b level=%0d out=%h out_zero=%b, required 0 1 0 00 0",
                     out_valid, in_ready, level, out, out_zero);
        end
`ifdef ONEHOT_DECODE8_ERRCHK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: err=%b required 0", err);
        end
`endif
        @(negedge clk);
        rst_n = 1;
        q.delete();
        idle();
    endtask

    task automatic test_single();
        step(1'b1, 3'd5, 1'b0, 1'b1);
        checks++;
        if (out !== 8'b0010_0000 || out_valid !== 1'b1 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL single_out: out=%b out_valid=%b, required 00100000 1", out, out_valid);
        end
        step(1'b0, 3'd0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out !== 8'h00 || level !== '0) begin
            errors++;
            $display("FAIL single_pop: out_valid=%b out=%h level=%0d, required 0 00 0", out_valid, out, level);
        end
    endtask

    task automatic test_full();
        logic [7:0] want;
        for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 1'b0, 1'b0);
        checks++;
        if (level !== LW'(4) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level: level=%0d in_ready=%b, required 4 0", level, in_ready);
        end
        step(1'b1, 3'd6, 1'b0, 1'b0);
        checks++;
        if (level !== LW'(4) || q.size() != 4) begin
            errors++;
            $display("FAIL full_refuse: level=%0d, required 4", level);
        end
        // hold: outputs stable while stalled
        checks++;
        if (out !== 8'h01 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: out=%h out_valid=%b, required 01 1", out, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            want = 8'h01 << i;
            checks++;
            if (out !== want) begin
                errors++;
                $display("FAIL drain_%0d: out=%h required %h", i, out, want);
            end
            step(1'b0, 3'd0, 1'b0, 1'b1);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 3'd1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 3'd7, 1'b0, 1'b1);
        checks++;
        if (level !== LW'(2) || out !== 8'h04) begin
            errors++;
            $display("FAIL b2b_level: level=%0d out=%h, required 2 04", level, out);
        end
        step(1'b0, 3'd0, 1'b0, 1'b1);
        checks++;
        if (out !== 8'b1000_0000 || level !== LW'(1)) begin
            errors++;
            $display("FAIL b2b_order: out=%b level=%0d, required 10000000 1", out, level);
        end
        step(1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_zero();
        step(1'b1, 3'd0, 1'b1, 1'b0);
        checks++;
        if (out !== 8'h00 || out_zero !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_entry: out=%h out_zero=%b out_valid=%b, required 00 1 1", out, out_zero, out_valid);
        end
`ifdef ONEHOT_DECODE8_ERRCHK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean: err=%b required 0", err);
        end
        step(1'b1, 3'd3, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b1 || out !== 8'h00 || out_zero !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b out=%h out_zero=%b, required 1 00 1", err, out, out_zero);
        end
        step(1'b0, 3'd0, 1'b0, 1'b1);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b required 1", err);
        end
`endif
        while (q.size() != 0) step(1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 3'(i + 4), 1'b0, 1'b0);
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b1 || out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: out_valid=%b level=%0d in_ready=%b out=%h, required 0 0 1 00",
                     out_valid, level, in_ready, out);
        end
`ifdef ONEHOT_DECODE8_ERRCHK_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_err: err=%b required 0", err);
        end
`endif
        // an edge while held in reset must not accept a push
        in_valid = 1; code = 3'd2; z = 0; out_ready = 1;
        @(posedge clk);
        #1;
        checks++;
        if (level !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_edge: level=%0d out_valid=%b, required 0 0", level, out_valid);
        end
        in_valid = 0;
        @(negedge clk);
        rst_n = 1;
        q.delete();
        step(1'b1, 3'd6, 1'b0, 1'b0);
        checks++;
        if (out !== 8'h40 || level !== LW'(1)) begin
            errors++;
            $display("FAIL resume: out=%h level=%0d, required 40 1", out, level);
        end
        step(1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic v;
        logic r;
        logic [2:0] c;
        logic zz;
        while ((got < DEPTH * 3) && (cyc < 600)) begin
            v  = (sent < DEPTH * 3) && ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            c  = 3'($urandom_range(0, 7));
            zz = ($urandom_range(0, 7) == 0);
            if (zz) c = 3'd0;
            checks++;
            if (out !== exp_out() || out_zero !== exp_zero() || level !== LW'(q.size())) begin
                errors++;
                $display("FAIL random_c%0d: out=%h zero=%b level=%0d, required %h %b %0d",
                         cyc, out, out_zero, level, exp_out(), exp_zero(), q.size());
            end
            if (v && q.size() < DEPTH) sent++;
            if (r && q.size() > 0) got++;
            step(v, c, zz, r);
            cyc++;
        end
        checks++;
        if (got != DEPTH * 3) begin
            errors++;
            $display("FAIL random_timeout: popped=%0d required %0d", got, DEPTH * 3);
        end
        checks++;
        if (out_valid !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL random_end: out_valid=%b level=%0d, required 0 0", out_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_zero();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_decode8.md
ONEHOT_DECODE8 -- requirements
Module: onehot_decode8

Interface
REQ-001 SHALL provide parameter: DEPTH, 4, number of buffer entries; power of two, 2..16.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: in_valid  input  1  code/z pair presented.
REQ-005 SHALL provide port: in_ready  output  1  buffer can accept a pair.
REQ-006 SHALL provide port: code  input  3  encoded index of highest set bit.
REQ-007 SHALL provide port: z  input  1  all-zero flag from the encoder side.
REQ-008 SHALL provide port: out_valid  output  1  decoded word available.
REQ-009 SHALL provide port: out_ready  input  1  consumer accepts the word.
REQ-010 SHALL provide port: out  output  8  one-hot decoded word.
REQ-011 SHALL provide port: out_zero  output  1  head entry had z=1.
REQ-012 SHALL provide port: level  output  clog2(DEPTH)+1  current entry count.
REQ-013 SHALL provide port: err  output  1  sticky inconsistency flag; present only with ONEHOT_DECODE8_ERRCHK_EN.

Function
REQ-014 SHALL accept a pair on a rising edge when in_valid=1 and in_ready=1; the pair is stored at the write pointer.
REQ-015 SHALL drive in_ready = (level != DEPTH); no push while full, even if a pop occurs in the same cycle.
REQ-016 SHALL drive out_valid = (level != 0); pop on a rising edge when out_valid=1 and out_ready=1.
REQ-017 SHALL decode the head entry: out = 8'b0 when z=1, else bit[code]=1 and all other bits 0; out_zero = stored z.
REQ-018 SHALL keep out, out_zero, and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL give one-cycle latency: a pair accepted into an empty buffer at edge N shows out_valid=1 after edge N.
REQ-020 SHALL allow a simultaneous push and pop when 0 < level < DEPTH; level is unchanged and order is preserved.
REQ-021 SHALL not pop when empty, even if out_ready=1; an empty-buffer push with out_ready=1 pops no earlier than the next edge.
REQ-022 SHALL use read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-023 SHALL drive out=8'b0 and out_zero=0 while out_valid=0.

Reset
REQ-024 SHALL, on rst_n=0, immediately clear both pointers and level, and set out_valid=0, in_ready=1, out=0, out_zero=0 and err=0.
REQ-025 SHALL discard all buffered entries on reset mid-operation; no pop or push completes on the edge at which rst_n is low.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n returns high.

Configuration
REQ-027 SHALL, with ONEHOT_DECODE8_ERRCHK_EN defined, set err to 1 on any accepted pair with z=1 and code!=3'b000, and hold err until reset; that entry still decodes to out=0, out_zero=1.
REQ-028 SHALL, without ONEHOT_DECODE8_ERRCHK_EN, omit the err port and check logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, then push code=5,z=0 with out_ready=1 -> next cycle out=8'b00100000, out_valid=1; popped on the following edge.
REQ-030 SHALL cover: out_ready=0, push codes 0,1,2,3 -> level=4, in_ready=0; a fifth push is refused; drain yields 01,02,04,08 in order.
REQ-031 SHALL cover: level=2, simultaneous push code=7 and pop -> level stays 2; 8'b10000000 emerges after the older entry.
REQ-032 SHALL cover: push z=1,code=0 -> out=0, out_zero=1, out_valid=1; with the macro, push z=1,code=3 -> err=1 until rst_n=0.
REQ-033 SHALL cover: 3 entries buffered, assert rst_n=0 mid-cycle -> out_valid=0, level=0 and in_ready=1 without waiting for a clock edge.
REQ-034 SHALL cover: DEPTH*3 push/pop pairs with random out_ready stalls -> output order matches input order across pointer wrap.
